sd_fifo_mc: RTL and testbench
=============================

Name: sd_fifo_mc

Overview:
- Multi-channel srdy/drdy FIFO. `channels` independent logical queues share one internal memory of `channels*chan_depth` entries.
- Single producer-facing input port: the channel is selected per beat, with per-channel write commit/abort.
- Single output port: round-robin arbitration across channels holding committed data.
- Used where several flows share one RAM instead of one big FIFO per flow. `chan_depth` need not be a power of 2.

Parameters:
- width, 8, data bits per entry
- chan_depth, 64, entries per channel (any value >= 2)
- channels, 4, number of logical queues (>= 2)
- wr_commit, 0, 1 = writes are invisible to the reader until c_commit; 0 = every write commits immediately
- csz, $clog2(channels), channel id width
- asz, $clog2(chan_depth), per-channel pointer width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- c_srdy  input  1  write data valid
- c_drdy  output  1  write accepted (channel c_chan not full)
- c_chan  input  csz  target channel of write/commit/abort
- c_commit  input  1  commit channel c_chan (wr_commit=1 only)
- c_abort  input  1  discard uncommitted writes of channel c_chan (wr_commit=1 only)
- c_data  input  width  write data
- p_srdy  output  1  output data valid
- p_drdy  input  1  output accepted
- p_chan  output  csz  channel of p_data
- p_data  output  width  output data
- usage  output  channels*(asz+1)  flattened per-channel occupancy; channel k at [k*(asz+1) +: asz+1]

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset:
  - all pointers, counts, the in-flight flag and the output buffer are cleared.
  - the round-robin pointer is set to channel 0.
  - outputs: p_srdy=0, usage=0, c_drdy=1 (all channels empty). p_data/p_chan are don't-care.
  - reset mid-operation drops all queued, uncommitted and in-flight data.
- Per-channel state:
  - cur_wrptr, com_wrptr, rdptr (0..chan_depth-1; increment wraps chan_depth-1 -> 0).
  - occ = uncommitted + committed entries not yet read-issued, range 0..chan_depth.
  - cocc = committed entries not yet issued.
- Memory address = chan*chan_depth + ptr. Memory is written at clk; read data is registered, 1-cycle latency.
- Write handshake:
  - c_drdy = (occ[c_chan] != chan_depth), combinational from registered state only.
  - A write occurs when c_srdy & c_drdy: mem[c_chan] <= c_data; cur_wrptr++; occ++.
- Commit / abort (wr_commit=0):
  - c_commit/c_abort are ignored.
  - com_wrptr tracks cur_wrptr; every write increments cocc that cycle.
- Commit / abort (wr_commit=1):
  - c_commit: com_wrptr <= cur_wrptr, including a write in the same cycle. cocc becomes occ (after that cycle's write/issue).
  - c_abort: cur_wrptr <= com_wrptr; occ <= cocc. A same-cycle write to that channel is discarded but still handshaken.
  - c_commit and c_abort together: commit wins, abort ignored.
  - Commit/abort are independent of c_srdy and take effect only on channel c_chan.
- Read arbitration:
  - Eligible channels: cocc != 0.
  - Issue condition: outbuf_count + inflight - pop < 2, where pop = p_srdy & p_drdy.
  - Grant: first eligible channel starting from the rr pointer. rr <= grant+1 (wrapping at channels-1 -> 0).
  - At most one read per cycle.
  - On issue: read mem at rdptr; rdptr++; occ--; cocc--. Space is freed on issue, not on pop.
  - Next cycle, the data plus grant channel are pushed into the 2-entry output buffer.
  - p_srdy = outbuf nonempty; p_data/p_chan come from its head.
  - Sustains 1 beat/clk with p_drdy held high.
- Latency: committed write into an idle, empty FIFO at cycle N -> read issue N+1 -> p_srdy=1 at N+2.
- Simultaneous events on the same channel in one cycle:
  - write and issue: occ is unchanged, cocc net per the rules above.
  - A full channel does not accept a write in the same cycle as its issue. There is no bypass.
- Ordering: strict FIFO within a channel. Across channels, order follows grant order.
- usage[k] = occ[k].

Test Plan:
- Reset, then write 0x11,0x22,0x33 to chan 1 (wr_commit=0) -> p_srdy rises 2 cycles after the first write; output sequence 0x11,0x22,0x33 with p_chan=1; then usage[1]=0.
- Fill chan 2 with chan_depth=5 entries while p_drdy=0 -> c_drdy=0 for c_chan=2 but 1 for c_chan=0; usage[2]=5 with 2 entries in outbuf/flight. Pop one -> c_drdy for chan 2 returns after the next issue.
- wr_commit=1: write A,B to chan 0, no commit -> p_srdy stays 0 for 10 cycles. Pulse c_commit -> A,B delivered. Write C, then c_abort -> C is never delivered; usage[0]=0.
- Same-cycle c_commit with write D -> D is included and delivered. Same-cycle c_abort with write E -> E is dropped. Both asserted -> commit wins.
- Channels 0..3 each preloaded with 4 entries, p_drdy=1 -> p_chan sequence 0,1,2,3,0,1,2,3,... at 1 beat/clk with no bubbles.
- Reset asserted while chan 3 holds 3 entries and one read is in flight -> next cycle p_srdy=0, usage=0, c_drdy=1.

Source files
------------

// File: rtl/sd_fifo_mc_if.sv
// Handshake bundle for sd_fifo_mc: write side (c_*) and read side (p_*).
// The FIFO uses the slave modport and the producer/consumer uses the master modport.
interface sd_fifo_mc_if #(
    parameter int width    = 8,
    parameter int channels = 4,
    parameter int csz      = $clog2(channels)
);
    logic             c_srdy;
    logic             c_drdy;
    logic [csz-1:0]   c_chan;
    logic             c_commit;
    logic             c_abort;
    logic [width-1:0] c_data;
    logic             p_srdy;
    logic             p_drdy;
    logic [csz-1:0]   p_chan;
    logic [width-1:0] p_data;

    modport master (
        output c_srdy, c_chan, c_commit, c_abort, c_data, p_drdy,
        input  c_drdy, p_srdy, p_chan, p_data
    );

    modport slave (
        input  c_srdy, c_chan, c_commit, c_abort, c_data, p_drdy,
        output c_drdy, p_srdy, p_chan, p_data
    );
endinterface

// File: rtl/sd_fifo_mc.sv
// Multi-channel srdy/drdy FIFO: several logical queues share one memory, with optional
// write commit/abort and a round-robin read side feeding a 2-entry output buffer.
module sd_fifo_mc #(
    parameter int width      = 8,
    parameter int chan_depth = 64,
    parameter int channels   = 4,
    parameter bit wr_commit  = 1'b0,
    parameter int csz        = $clog2(channels),
    parameter int asz        = $clog2(chan_depth)
) (
    input  logic                        clk,
    input  logic                        reset,
    sd_fifo_mc_if.slave                 io,
    output logic [channels*(asz+1)-1:0] usage
);
    localparam int             msz      = $clog2(channels*chan_depth);
    localparam logic [asz:0]   full_cnt = (asz+1)'(chan_depth);
    localparam logic [asz-1:0] last_ptr = asz'(chan_depth-1);

    logic [width-1:0] mem [channels*chan_depth];

    logic [asz-1:0] cur_wrptr [channels];
    logic [asz-1:0] com_wrptr [channels];
    logic [asz-1:0] rdptr     [channels];
    logic [asz:0]   occ       [channels];
    logic [asz:0]   cocc      [channels];
    logic [asz:0]   occ_net   [channels];
    logic [asz:0]   cocc_net  [channels];
    logic [asz:0]   cocc_dec  [channels];

    logic [channels-1:0] wr_hit, iss_hit, com_hit, abt_hit;

    logic [csz-1:0]   rr, grant, inflight_chan;
    logic             grant_vld, issue, inflight, wr_en, pop;
    logic [2:0]       pending;
    logic [width-1:0] rd_data;

    logic [width-1:0] ob_data [2];
    logic [csz-1:0]   ob_chan [2];
    logic             ob_head;
    logic [1:0]       ob_count;

    function automatic logic [asz-1:0] ptr_inc(input logic [asz-1:0] p);
        return (p == last_ptr) ? '0 : p + asz'(1);
    endfunction

    function automatic logic [msz-1:0] mem_addr(input logic [csz-1:0] ch, input logic [asz-1:0] p);
        return msz'(ch) * msz'(chan_depth) + msz'(p);
    endfunction

    function automatic logic [csz-1:0] rr_plus(input logic [csz-1:0] base, input int i);
        int v;
        v = int'(base) + i;
        if (v >= channels) v = v - channels;
        return csz'(v);
    endfunction

    assign wr_en     = io.c_srdy & io.c_drdy;
    assign pop       = io.p_srdy & io.p_drdy;
    assign io.c_drdy = (occ[io.c_chan] != full_cnt);
    assign io.p_srdy = (ob_count != 2'd0);
    assign io.p_data = ob_data[ob_head];
    assign io.p_chan = ob_chan[ob_head];

    // Issue only while the output buffer plus the read in flight can still absorb a beat.
    assign pending = 3'(ob_count) + 3'(inflight);
    assign issue   = grant_vld && (pending < (pop ? 3'd3 : 3'd2));

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < channels; i++) begin
            if (!grant_vld && cocc[rr_plus(rr, i)] != '0) begin
                grant     = rr_plus(rr, i);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        usage = '0;
        for (int k = 0; k < channels; k++) begin
            wr_hit[k]   = wr_en && (io.c_chan == csz'(k));
            iss_hit[k]  = issue && (grant == csz'(k));
            com_hit[k]  = wr_commit && io.c_commit && (io.c_chan == csz'(k));
            abt_hit[k]  = wr_commit && io.c_abort && !io.c_commit && (io.c_chan == csz'(k));
            occ_net[k]  = occ[k] + (asz+1)'(wr_hit[k]) - (asz+1)'(iss_hit[k]);
            cocc_net[k] = cocc[k] + (asz+1)'(wr_hit[k]) - (asz+1)'(iss_hit[k]);
            cocc_dec[k] = cocc[k] - (asz+1)'(iss_hit[k]);
            usage[k*(asz+1) +: asz+1] = occ[k];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[mem_addr(io.c_chan, cur_wrptr[io.c_chan])] <= io.c_data;
        if (issue) rd_data <= mem[mem_addr(grant, rdptr[grant])];
    end

    // An abort rewinds the write side to the last commit, discarding any same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < channels; k++) begin
                cur_wrptr[k] <= '0;
                com_wrptr[k] <= '0;
                rdptr[k]     <= '0;
                occ[k]       <= '0;
                cocc[k]      <= '0;
            end
        end else begin
            for (int k = 0; k < channels; k++) begin
                if (abt_hit[k]) begin
                    cur_wrptr[k] <= com_wrptr[k];
                    occ[k]       <= cocc_dec[k];
                end else begin
                    if (wr_hit[k]) cur_wrptr[k] <= ptr_inc(cur_wrptr[k]);
                    occ[k] <= occ_net[k];
                end
                if (!wr_commit) begin
                    if (wr_hit[k]) com_wrptr[k] <= ptr_inc(com_wrptr[k]);
                    cocc[k] <= cocc_net[k];
                end else if (com_hit[k]) begin
                    com_wrptr[k] <= wr_hit[k] ? ptr_inc(cur_wrptr[k]) : cur_wrptr[k];
                    cocc[k]      <= occ_net[k];
                end else begin
                    cocc[k] <= cocc_dec[k];
                end
                if (iss_hit[k]) rdptr[k] <= ptr_inc(rdptr[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
            rr       <= '0;
            ob_head  <= 1'b0;
            ob_count <= 2'd0;
        end else begin
            inflight <= issue;
            if (issue) rr <= (grant == csz'(channels-1)) ? '0 : grant + csz'(1);
            if (pop) ob_head <= ~ob_head;
            ob_count <= ob_count + 2'(inflight) - 2'(pop);
        end
    end

    // Slot head^count[0] is the tail; with two entries and a pop it is the slot being freed.
    always_ff @(posedge clk) begin
        if (issue) inflight_chan <= grant;
        if (inflight) begin
            ob_data[ob_head ^ ob_count[0]] <= rd_data;
            ob_chan[ob_head ^ ob_count[0]] <= inflight_chan;
        end
    end
endmodule

// File: tb/tb_sd_fifo_mc.sv
// Bench for sd_fifo_mc: one instance per wr_commit mode, shared stimulus, queue-based
// reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_sd_fifo_mc;
    localparam int W   = 8;
    localparam int D   = 5;
    localparam int C   = 4;
    localparam int CSZ = 2;
    localparam int ASZ = 3;
    localparam int UW  = C*(ASZ+1);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           c_srdy = 1'b0;
    logic           c_commit = 1'b0;
    logic           c_abort = 1'b0;
    logic           p_drdy = 1'b0;
    logic [CSZ-1:0] c_chan = '0;
    logic [W-1:0]   c_data = '0;
    logic [UW-1:0]  usage0, usage1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    sd_fifo_mc_if #(.width(W), .channels(C)) bus0 ();
    sd_fifo_mc_if #(.width(W), .channels(C)) bus1 ();

    assign bus0.c_srdy = c_srdy;  assign bus1.c_srdy = c_srdy;
    assign bus0.c_chan = c_chan;  assign bus1.c_chan = c_chan;
    assign bus0.c_commit = c_commit;  assign bus1.c_commit = c_commit;
    assign bus0.c_abort = c_abort;  assign bus1.c_abort = c_abort;
    assign bus0.c_data = c_data;  assign bus1.c_data = c_data;
    assign bus0.p_drdy = p_drdy;  assign bus1.p_drdy = p_drdy;

    sd_fifo_mc #(.width(W), .chan_depth(D), .channels(C), .wr_commit(1'b0)) dut0 (
        .clk(clk), .reset(reset), .io(bus0.slave), .usage(usage0));
    sd_fifo_mc #(.width(W), .chan_depth(D), .channels(C), .wr_commit(1'b1)) dut1 (
        .clk(clk), .reset(reset), .io(bus1.slave), .usage(usage1));

    function automatic logic get_psrdy(input int m);
        return (m == 0) ? bus0.p_srdy : bus1.p_srdy;
    endfunction
    function automatic logic get_cdrdy(input int m);
        return (m == 0) ? bus0.c_drdy : bus1.c_drdy;
    endfunction
    function automatic logic [CSZ+W-1:0] get_beat(input int m);
        return (m == 0) ? {bus0.p_chan, bus0.p_data} : {bus1.p_chan, bus1.p_data};
    endfunction
    function automatic logic [ASZ:0] get_usage(input int m, input int k);
        logic [UW-1:0] u;
        u = (m == 0) ? usage0 : usage1;
        return u[k*(ASZ+1) +: ASZ+1];
    endfunction

    // Reference model: per channel a committed and an uncommitted queue; the read side is
    // one optional in-flight beat followed by an output queue of at most two beats.
    logic [W-1:0]     comq [2*C][$];
    logic [W-1:0]     uncq [2*C][$];
    logic [CSZ+W-1:0] outq [2][$];
    logic [CSZ+W-1:0] infl [2];
    bit               infl_v [2];
    int               rr_m [2];
    bit               model_on = 1'b0;

    logic [CSZ+W-1:0] pops [2][$];
    bit               rise_seen = 1'b0;
    int               rise_edge = 0;

    function automatic int model_occ(input int m, input int ch);
        return comq[m*C+ch].size() + uncq[m*C+ch].size();
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2*C; i++) begin
            comq[i].delete();
            uncq[i].delete();
        end
        for (int m = 0; m < 2; m++) begin
            outq[m].delete();
            infl_v[m] = 1'b0;
            rr_m[m]   = 0;
        end
    endtask

    task automatic modelStep(input int m);
        bit pop, iss, accept;
        int g, ch, idx;
        ch     = int'(c_chan);
        pop    = (outq[m].size() > 0) && p_drdy;
        accept = c_srdy && (model_occ(m, ch) != D);
        iss    = 1'b0;
        g      = 0;
        if (outq[m].size() + int'(infl_v[m]) - int'(pop) < 2) begin
            for (int i = 0; i < C; i++) begin
                idx = (rr_m[m] + i) % C;
                if (!iss && comq[m*C+idx].size() > 0) begin
                    iss = 1'b1;
                    g   = idx;
                end
            end
        end
        if (pop) void'(outq[m].pop_front());
        if (infl_v[m]) outq[m].push_back(infl[m]);
        infl_v[m] = iss;
        if (iss) begin
            infl[m] = {CSZ'(g), comq[m*C+g].pop_front()};
            rr_m[m] = (g + 1) % C;
        end
        if (accept) begin
            if (m == 0) comq[m*C+ch].push_back(c_data);
            else        uncq[m*C+ch].push_back(c_data);
        end
        if (m == 1 && c_commit) begin
            while (uncq[m*C+ch].size() > 0) comq[m*C+ch].push_back(uncq[m*C+ch].pop_front());
        end else if (m == 1 && c_abort) begin
            uncq[m*C+ch].delete();
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            modelReset();
            model_on = 1'b1;
        end else begin
            for (int m = 0; m < 2; m++) modelStep(m);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            for (int m = 0; m < 2; m++) begin
                checkOutput($sformatf("p_srdy[%0d]", m), 32'(get_psrdy(m)), 32'(outq[m].size() > 0));
                if (outq[m].size() > 0)
                    checkOutput($sformatf("p_chan_data[%0d]", m), 32'(get_beat(m)), 32'(outq[m][0]));
                for (int k = 0; k < C; k++)
                    checkOutput($sformatf("usage[%0d][%0d]", m, k), 32'(get_usage(m, k)), 32'(model_occ(m, k)));
                checkOutput($sformatf("c_drdy[%0d]", m), 32'(get_cdrdy(m)),
                            32'(model_occ(m, int'(c_chan)) != D));
            end
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++)
            if (get_psrdy(m) === 1'b1 && p_drdy) pops[m].push_back(get_beat(m));
        if (!rise_seen && bus0.p_srdy === 1'b1) begin
            rise_seen = 1'b1;
            rise_edge = cyc;
        end
    end

    task automatic applyStimulus(input logic srdy, input logic [CSZ-1:0] ch, input logic [W-1:0] d,
                                 input logic com, input logic abt, input logic drdy);
        c_srdy   = srdy;
        c_chan   = ch;
        c_data   = d;
        c_commit = com;
        c_abort  = abt;
        p_drdy   = drdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic drdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, drdy);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle(2, 1'b0);
        reset = 1'b0;
    endtask

    task automatic clearPops();
        pops[0].delete();
        pops[1].delete();
    endtask

    task automatic checkPops(input int m, input string name, input logic [CSZ+W-1:0] exp [$]);
        checkOutput({name, "_count"}, 32'(pops[m].size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < pops[m].size(); i++)
            checkOutput($sformatf("%s_beat%0d", name, i), 32'(pops[m][i]), 32'(exp[i]));
    endtask

    initial begin
        int first_edge;
        logic [CSZ+W-1:0] exp [$];

        doReset();
        for (int m = 0; m < 2; m++) begin
            checkOutput("reset_p_srdy", 32'(get_psrdy(m)), 32'd0);
            checkOutput("reset_usage", 32'(m == 0 ? usage0 : usage1), 32'd0);
            checkOutput("reset_c_drdy", 32'(get_cdrdy(m)), 32'd1);
        end

        // Three beats on channel 1, immediate commit instance
        clearPops();
        rise_seen = 1'b0;
        applyStimulus(1'b1, 2'd1, 8'h11, 1'b0, 1'b0, 1'b1);
        first_edge = cyc;
        applyStimulus(1'b1, 2'd1, 8'h22, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'd1, 8'h33, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b1);
        checkOutput("first_latency", 32'(rise_edge - first_edge), 32'd2);
        exp = '{10'h111, 10'h122, 10'h133};
        checkPops(0, "chan1_seq", exp);
        checkOutput("chan1_usage_drained", 32'(get_usage(0, 1)), 32'd0);

        // Fill channel 2 with the output stalled
        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'd2, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        c_srdy = 1'b0;
        c_chan = 2'd2;
        #1;
        checkOutput("full_c_drdy_ch2", 32'(bus0.c_drdy), 32'd0);
        checkOutput("full_usage_ch2", 32'(get_usage(0, 2)), 32'd5);
        checkOutput("uncommitted_full_c_drdy", 32'(bus1.c_drdy), 32'd0);
        c_chan = 2'd0;
        #1;
        checkOutput("full_c_drdy_ch0", 32'(bus0.c_drdy), 32'd1);
        applyStimulus(1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("refill_c_drdy_ch2", 32'(bus0.c_drdy), 32'd1);
        checkOutput("refill_usage_ch2", 32'(get_usage(0, 2)), 32'd4);
        idle(1, 1'b0);

        // Commit / abort on the wr_commit=1 instance
        doReset();
        clearPops();
        applyStimulus(1'b1, 2'd0, 8'hA1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'hB2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            idle(1, 1'b1);
            checkOutput("uncommitted_hidden", 32'(bus1.p_srdy), 32'd0);
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(6, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'hC3, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        idle(6, 1'b1);
        exp = '{10'h0A1, 10'h0B2};
        checkPops(1, "commit_seq", exp);
        checkOutput("abort_usage_ch0", 32'(get_usage(1, 0)), 32'd0);

        clearPops();
        applyStimulus(1'b1, 2'd0, 8'hD4, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'hE5, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'hF6, 1'b1, 1'b1, 1'b1);
        idle(6, 1'b1);
        exp = '{10'h0D4, 10'h0F6};
        checkPops(1, "same_cycle_seq", exp);

        // Round robin across four preloaded channels
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'(i % 4), 8'(i), 1'b1, 1'b0, 1'b0);
        clearPops();
        idle(16, 1'b1);
        exp.delete();
        for (int i = 0; i < 16; i++) exp.push_back({2'(i % 4), 8'(i)});
        checkPops(0, "rr_seq0", exp);
        checkPops(1, "rr_seq1", exp);

        // Reset while channel 3 holds data with a read in flight
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd3, 8'(8'h70 + i), 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        idle(1, 1'b0);
        reset = 1'b0;
        for (int m = 0; m < 2; m++) begin
            checkOutput("midreset_p_srdy", 32'(get_psrdy(m)), 32'd0);
            checkOutput("midreset_usage", 32'(m == 0 ? usage0 : usage1), 32'd0);
            checkOutput("midreset_c_drdy", 32'(get_cdrdy(m)), 32'd1);
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            applyStimulus($urandom_range(0, 9) < 7, 2'($urandom_range(0, C-1)), 8'($urandom),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) < 6);
        end
        reset = 1'b0;
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
